grf_write_arbiter: RTL

GRF_WRITE_ARBITER -- requirements
Module: grf_write_arbiter

---
 rtl/grf_write_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/grf_write_arbiter.sv
// rtl/grf_write_arbiter.sv - GRF write-port arbiter between pipeline writeback and a queued mult/div result path,
// with an MD-pending scoreboard driving the decode stall.
module grf_write_arbiter #(
  parameter int QDEPTH     = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  output logic        wb_stall,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  input  logic [31:0] md_pc,
  output logic        md_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        stall,
  output logic        grf_we,
  output logic [4:0]  grf_rd,
  output logic [31:0] grf_wdata,
  output logic [31:0] grf_pc
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [4:0]    qRd   [QDEPTH];
  logic [31:0]   qData [QDEPTH];
  logic [31:0]   qPc   [QDEPTH];
  logic [PW-1:0] headPtr, tailPtr;
  logic [CW-1:0] count;
  logic [SW-1:0] starveCnt;
  logic [31:0]   busy, busyNext;

  logic wbEff, qEmpty, qFull, forceMd, push, pop;

  always_comb begin
    wbEff   = wb_valid && (wb_rd != 5'd0);
    qEmpty  = (count == '0);
    qFull   = (count == CW'(QDEPTH));
    forceMd = !qEmpty && (starveCnt == SW'(STARVE_LIM));
    // The head drains when forced, or whenever no effective WB claims the port.
    pop     = !qEmpty && (forceMd || !wbEff);
    // md_rd=0 results are acknowledged but never occupy a slot.
    push    = md_valid && !qFull && (md_rd != 5'd0);
  end

  always_comb begin
    busyNext = busy;
    if (pop)
      busyNext[qRd[headPtr]] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0))
      busyNext[issue_rd] = 1'b1;
    busyNext[0] = 1'b0;
  end

  assign md_ready = !Rst && !qFull;
  assign wb_stall = !Rst && forceMd;
  assign stall    = !Rst && (((rs != 5'd0) && busy[rs]) ||
                             ((rt != 5'd0) && busy[rt]) ||
                             (issue_valid && busy[issue_rd]));

  // Queue storage needs no reset; validity is tracked by count.
  always_ff @(posedge Clk) begin
    if (!Rst && push) begin
      qRd[tailPtr]   <= md_rd;
      qData[tailPtr] <= md_data;
      qPc[tailPtr]   <= md_pc;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      count     <= '0;
      starveCnt <= '0;
      busy      <= '0;
      grf_we    <= 1'b0;
      grf_rd    <= 5'd0;
      grf_wdata <= 32'd0;
      grf_pc    <= 32'd0;
    end else begin
      if (push)
        tailPtr <= tailPtr + PW'(1);
      if (pop)
        headPtr <= headPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (qEmpty || pop)
        starveCnt <= '0;
      else if (wbEff && (starveCnt != SW'(STARVE_LIM)))
        starveCnt <= starveCnt + SW'(1);

      busy <= busyNext;

      if (pop) begin
        grf_we    <= 1'b1;
        grf_rd    <= qRd[headPtr];
        grf_wdata <= qData[headPtr];
        grf_pc    <= qPc[headPtr];
      end else if (wbEff) begin
        grf_we    <= 1'b1;
        grf_rd    <= wb_rd;
        grf_wdata <= wb_data;
        grf_pc    <= wb_pc;
      end else begin
        grf_we    <= 1'b0;
      end
    end
  end

endmodule
